// File: rtl/ct_f_spsram_param_if.sv
// rtl/ct_f_spsram_param_if.sv - access bus for the parameterised single-port SRAM
interface ct_f_spsram_param_if #(
  parameter int DATA_W = 59,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] A;
  logic              CEN;
  logic              GWEN;
  logic [DATA_W-1:0] WEN;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;
  logic              INIT_DONE;
  logic              ACC_ERR;

  modport master (
    output A, CEN, GWEN, WEN, D,
    input  Q, INIT_DONE, ACC_ERR
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D,
    output Q, INIT_DONE, ACC_ERR
  );
endinterface

// File: rtl/ct_f_spsram_param.sv
// rtl/ct_f_spsram_param.sv - single-port SRAM with segment write mask and post-reset zero fill
module ct_f_spsram_param #(
  parameter int DATA_W  = 59,
  parameter int ADDR_W  = 11,
  parameter int SEG_W   = 29,
  parameter int OUT_REG = 0,
  parameter int INIT_EN = 1
) (
  input logic                 CLK,
  input logic                 RST_B,
  ct_f_spsram_param_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_pipe;
  logic              r_init_done;
  logic              r_acc_err;

  logic [DATA_W-1:0] w_bmask;
  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_merged;
  logic              w_access;
  logic              w_ext_we;

  // Each segment is governed by the WEN bit at its own MSB; the last segment may be short.
  function automatic int seg_msb(input int b);
    int top;
    top = (b / SEG_W) * SEG_W + SEG_W - 1;
    return (top > DATA_W - 1) ? DATA_W - 1 : top;
  endfunction

  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < DATA_W; b++) begin
      w_bmask[b] = ~bus.WEN[seg_msb(b)];
    end
    w_access = (r_state == ST_READY) && !bus.CEN;
    w_ext_we = w_access && !bus.GWEN;
    w_cur    = r_mem[bus.A];
    w_merged = w_ext_we ? ((w_cur & ~w_bmask) | (bus.D & w_bmask)) : w_cur;
  end

  // Array has no reset so contents survive a reset when the zero fill is disabled.
  always_ff @(posedge CLK) begin
    if (RST_B) begin
      if (r_state == ST_INIT) begin
        r_mem[r_init_cnt] <= '0;
      end else if (w_ext_we) begin
        r_mem[bus.A] <= w_merged;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_state     <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      r_init_cnt  <= '0;
      r_addr      <= '0;
      r_q         <= '0;
      r_pipe      <= '0;
      r_acc_err   <= 1'b0;
      r_init_done <= (INIT_EN == 0);
    end else begin
      r_pipe      <= r_q;
      r_init_done <= (r_state == ST_READY);
      case (r_state)
        ST_INIT: begin
          r_q <= '0;
          if (!bus.CEN) begin
            r_acc_err <= 1'b1;
          end
          if (r_init_cnt == {ADDR_W{1'b1}}) begin
            r_state <= ST_READY;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        default: begin
          if (!bus.CEN) begin
            r_addr <= bus.A;
            r_q    <= w_merged;
          end else begin
            r_q    <= r_mem[r_addr];
          end
        end
      endcase
    end
  end

  assign bus.Q         = (OUT_REG != 0) ? r_pipe : r_q;
  assign bus.INIT_DONE = r_init_done;
  assign bus.ACC_ERR   = r_acc_err;
endmodule

// File: tb/tb_ct_f_spsram_param.sv
// tb/tb_ct_f_spsram_param.sv - directed self-checking bench for ct_f_spsram_param
module tb_ct_f_spsram_param;
  localparam logic [58:0] ONES  = {59{1'b1}};
  localparam logic [58:0] HI30  = 59'h7FFFFFFE0000000;
  localparam logic [58:0] HI30M = 59'h3FFFFFFE0000000;

  logic clk;
  logic rst0_b;
  logic rst1_b;
  int   vectors;
  int   miscompares;

  ct_f_spsram_param_if #(.DATA_W(59), .ADDR_W(11)) bus0 ();
  ct_f_spsram_param_if #(.DATA_W(59), .ADDR_W(4))  bus1 ();

  ct_f_spsram_param dut0 (
    .CLK   (clk),
    .RST_B (rst0_b),
    .bus   (bus0.slave)
  );

  ct_f_spsram_param #(
    .DATA_W(59), .ADDR_W(4), .SEG_W(29), .OUT_REG(1), .INIT_EN(0)
  ) dut1 (
    .CLK   (clk),
    .RST_B (rst1_b),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus0.CEN  = 1'b1;
    bus0.GWEN = 1'b1;
    bus0.WEN  = ONES;
  endtask

  task automatic test_reset();
    rst0_b = 1'b0;
    idle0();
    bus0.A = '0;
    bus0.D = '0;
    tick();
    tick();
    vectors++;
    if (bus0.Q !== 59'd0) begin
      miscompares++; $display("FAIL reset_q got %h want 0", bus0.Q);
    end
    vectors++;
    if (bus0.INIT_DONE !== 1'b0) begin
      miscompares++; $display("FAIL reset_init_done got %b want 0", bus0.INIT_DONE);
    end
    vectors++;
    if (bus0.ACC_ERR !== 1'b0) begin
      miscompares++; $display("FAIL reset_acc_err got %b want 0", bus0.ACC_ERR);
    end
  endtask

  task automatic test_init_acc_err();
    int done_at;
    int q_bad;
    done_at = 0;
    q_bad   = 0;
    rst0_b  = 1'b1;
    for (int c = 1; c <= 3000 && done_at == 0; c++) begin
      if (c == 101) begin
        bus0.CEN = 1'b0; bus0.GWEN = 1'b0; bus0.A = 11'd3; bus0.D = ONES; bus0.WEN = '0;
      end else begin
        idle0();
      end
      tick();
      if (bus0.INIT_DONE === 1'b1) done_at = c;
      else if (bus0.Q !== 59'd0) q_bad++;
      if (c == 101) begin
        vectors++;
        if (bus0.ACC_ERR !== 1'b1) begin
          miscompares++; $display("FAIL acc_err_set got %b want 1", bus0.ACC_ERR);
        end
      end
    end
    idle0();
    vectors++;
    if (done_at != 2049) begin
      miscompares++; $display("FAIL init_done_edge got %0d want 2049", done_at);
    end
    vectors++;
    if (q_bad != 0) begin
      miscompares++; $display("FAIL init_q_zero got %0d nonzero cycles want 0", q_bad);
    end
    vectors++;
    if (bus0.ACC_ERR !== 1'b1) begin
      miscompares++; $display("FAIL acc_err_sticky got %b want 1", bus0.ACC_ERR);
    end
    bus0.CEN = 1'b0; bus0.A = 11'd3;
    tick();
    idle0();
    vectors++;
    if (bus0.Q !== 59'd0) begin
      miscompares++; $display("FAIL init_write_blocked got %h want 0", bus0.Q);
    end
  endtask

  task automatic test_read_all();
    int bad;
    bad = 0;
    for (int a = 0; a < 2048; a++) begin
      bus0.CEN = 1'b0; bus0.A = 11'(a);
      tick();
      if (bus0.Q !== 59'd0) bad++;
    end
    idle0();
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL read_all_zero got %0d bad addresses want 0", bad);
    end
  endtask

  task automatic test_write_read();
    bus0.CEN = 1'b0; bus0.GWEN = 1'b0; bus0.WEN = '0; bus0.A = 11'd5; bus0.D = ONES;
    tick();
    vectors++;
    if (bus0.Q !== ONES) begin
      miscompares++; $display("FAIL write_first got %h want %h", bus0.Q, ONES);
    end
    bus0.GWEN = 1'b1; bus0.A = 11'd0;
    tick();
    vectors++;
    if (bus0.Q !== 59'd0) begin
      miscompares++; $display("FAIL read_a0 got %h want 0", bus0.Q);
    end
    bus0.A = 11'd5;
    tick();
    vectors++;
    if (bus0.Q !== ONES) begin
      miscompares++; $display("FAIL read_a5 got %h want %h", bus0.Q, ONES);
    end
    idle0();
  endtask

  task automatic test_partial_write();
    bus0.CEN = 1'b0; bus0.GWEN = 1'b0; bus0.A = 11'd5; bus0.D = '0;
    bus0.WEN = ONES; bus0.WEN[28] = 1'b0;
    tick();
    vectors++;
    if (bus0.Q !== HI30) begin
      miscompares++; $display("FAIL seg0_write got %h want %h", bus0.Q, HI30);
    end
    bus0.WEN = ONES; bus0.WEN[58] = 1'b0;
    tick();
    vectors++;
    if (bus0.Q !== HI30M) begin
      miscompares++; $display("FAIL seg2_write got %h want %h", bus0.Q, HI30M);
    end
    bus0.WEN = ONES; bus0.WEN[57:29] = '0; bus0.WEN[28] = 1'b0; bus0.WEN[58] = 1'b0;
    bus0.WEN[57] = 1'b1; bus0.WEN[28] = 1'b1; bus0.WEN[58] = 1'b1; bus0.D = '0;
    tick();
    vectors++;
    if (bus0.Q !== HI30M) begin
      miscompares++; $display("FAIL masked_as_read got %h want %h", bus0.Q, HI30M);
    end
    bus0.GWEN = 1'b1; bus0.WEN = '0; bus0.D = '0;
    tick();
    vectors++;
    if (bus0.Q !== HI30M) begin
      miscompares++; $display("FAIL gwen_high_no_write got %h want %h", bus0.Q, HI30M);
    end
    idle0();
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    bus0.CEN = 1'b0; bus0.GWEN = 1'b0; bus0.WEN = '0; bus0.A = 11'd7; bus0.D = 59'd1;
    tick();
    bus0.GWEN = 1'b1; bus0.WEN = ONES; bus0.D = '0; bus0.A = 11'd5;
    tick();
    bus0.A = 11'd7;
    tick();
    vectors++;
    if (bus0.Q !== 59'd1) begin
      miscompares++; $display("FAIL read_a7 got %h want 1", bus0.Q);
    end
    bus0.CEN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus0.A = 11'($urandom_range(0, 2047));
      bus0.D = {$urandom(), $urandom()};
      tick();
      if (bus0.Q !== 59'd1) bad++;
    end
    idle0();
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL hold_stable got %0d changed cycles want 0", bad);
    end
  endtask

  task automatic test_reset_restart();
    int done_at;
    done_at = 0;
    rst0_b = 1'b0;
    tick();
    vectors++;
    if (bus0.ACC_ERR !== 1'b0) begin
      miscompares++; $display("FAIL acc_err_cleared got %b want 0", bus0.ACC_ERR);
    end
    rst0_b = 1'b1;
    for (int c = 0; c < 1000; c++) tick();
    vectors++;
    if (bus0.INIT_DONE !== 1'b0) begin
      miscompares++; $display("FAIL mid_init_done got %b want 0", bus0.INIT_DONE);
    end
    rst0_b = 1'b0;
    tick();
    rst0_b = 1'b1;
    for (int c = 1; c <= 3000 && done_at == 0; c++) begin
      tick();
      if (bus0.INIT_DONE === 1'b1) done_at = c;
    end
    vectors++;
    if (done_at != 2049) begin
      miscompares++; $display("FAIL restart_done_edge got %0d want 2049", done_at);
    end
    bus0.CEN = 1'b0; bus0.A = 11'd5;
    tick();
    idle0();
    vectors++;
    if (bus0.Q !== 59'd0) begin
      miscompares++; $display("FAIL restart_fill got %h want 0", bus0.Q);
    end
  endtask

  task automatic test_outreg_noinit();
    rst1_b = 1'b0;
    bus1.CEN = 1'b1; bus1.GWEN = 1'b1; bus1.WEN = ONES; bus1.A = '0; bus1.D = '0;
    tick();
    tick();
    vectors++;
    if (bus1.INIT_DONE !== 1'b1 || bus1.Q !== 59'd0) begin
      miscompares++; $display("FAIL noinit_reset got done=%b q=%h want done=1 q=0", bus1.INIT_DONE, bus1.Q);
    end
    rst1_b = 1'b1;
    bus1.CEN = 1'b0; bus1.GWEN = 1'b0; bus1.WEN = '0; bus1.A = 4'd5; bus1.D = ONES;
    tick();
    bus1.A = 4'd2; bus1.D = '0;
    tick();
    vectors++;
    if (bus1.Q !== ONES) begin
      miscompares++; $display("FAIL outreg_latency2 got %h want %h", bus1.Q, ONES);
    end
    bus1.GWEN = 1'b1;
    tick();
    vectors++;
    if (bus1.Q !== 59'd0) begin
      miscompares++; $display("FAIL outreg_next got %h want 0", bus1.Q);
    end
    rst1_b = 1'b0;
    bus1.CEN = 1'b1;
    tick();
    rst1_b = 1'b1;
    bus1.CEN = 1'b0; bus1.A = 4'd5;
    tick();
    vectors++;
    if (bus1.Q !== 59'd0) begin
      miscompares++; $display("FAIL outreg_pipe_reset got %h want 0", bus1.Q);
    end
    bus1.CEN = 1'b1;
    tick();
    vectors++;
    if (bus1.Q !== ONES) begin
      miscompares++; $display("FAIL reset_keeps_array got %h want %h", bus1.Q, ONES);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst0_b      = 1'b0;
    rst1_b      = 1'b0;
    bus0.A = '0; bus0.D = '0; bus0.CEN = 1'b1; bus0.GWEN = 1'b1; bus0.WEN = ONES;
    bus1.A = '0; bus1.D = '0; bus1.CEN = 1'b1; bus1.GWEN = 1'b1; bus1.WEN = ONES;
    test_reset();
    test_init_acc_err();
    test_read_all();
    test_write_read();
    test_partial_write();
    test_hold();
    test_reset_restart();
    test_outreg_noinit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ct_f_spsram_param.md
CT_F_SPSRAM_PARAM -- requirements
Module: ct_f_spsram_param

Interface
REQ-001 The block SHALL expose these parameters: DATA_W, default 59, data width in bits.
REQ-002 The block SHALL expose: ADDR_W, default 11, address width; depth is 2^ADDR_W entries.
REQ-003 The block SHALL expose: SEG_W, default 29, write-segment width; NSEG = ceil(DATA_W/SEG_W); the last segment holds the remaining DATA_W-(NSEG-1)*SEG_W bits.
REQ-004 The block SHALL expose: OUT_REG, default 0, output pipeline register enable (0 or 1).
REQ-005 The block SHALL expose: INIT_EN, default 1, zero-fill of the whole array after reset (0 or 1).
REQ-006 Port CLK, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-007 Port RST_B, input, 1 bit: synchronous, active-low reset.
REQ-008 Port A, input, ADDR_W bits: access address.
REQ-009 Port CEN, input, 1 bit: chip enable, active-low.
REQ-010 Port GWEN, input, 1 bit: global write enable, active-low.
REQ-011 Port WEN, input, DATA_W bits: per-bit write mask, active-low; only the MSB of each segment is sampled.
REQ-012 Port D, input, DATA_W bits: write data.
REQ-013 Port Q, output, DATA_W bits: read data.
REQ-014 Port INIT_DONE, output, 1 bit: high when the array is ready for external access.
REQ-015 Port ACC_ERR, output, 1 bit: sticky flag set by an access attempted before INIT_DONE.

Function
REQ-016 FSM states SHALL be INIT and READY; reset enters INIT if INIT_EN=1, otherwise READY.
REQ-017 In INIT the block SHALL write all-zero to entry init_cnt each cycle, starting at 0 and incrementing by 1.
REQ-018 After writing entry 2^ADDR_W-1 the FSM SHALL go to READY; INIT_DONE rises on the following edge, exactly 2^ADDR_W cycles after the first clock with RST_B high.
REQ-019 In INIT, external CEN=0 SHALL be ignored (no write, no address capture) and SHALL set ACC_ERR, which is cleared only by reset.
REQ-020 In READY, CEN=0 SHALL capture A into an address-hold register; CEN=1 SHALL read from the held address.
REQ-021 Segment s SHALL be written when all hold: READY, CEN=0, GWEN=0, WEN[min(s*SEG_W+SEG_W-1, DATA_W-1)]=0; segment data is D for that bit range.
REQ-022 Read latency SHALL be 1 cycle after the CEN=0 edge when OUT_REG=0, and 2 cycles when OUT_REG=1.
REQ-023 On a write cycle, the Q update SHALL show new D for written segments and prior contents for unwritten segments (write-first per segment).
REQ-024 With CEN=1, Q SHALL track the current contents of the held address at the same latency, so Q is stable when no write occurs.
REQ-025 Address wrap: init_cnt SHALL NOT wrap; the FSM leaves INIT exactly at the top entry.
REQ-026 GWEN=0 with all sampled WEN bits high SHALL behave as a read.

Reset
REQ-027 When RST_B=0 at a clock edge, the block SHALL set: Q=0, the pipeline register=0, ACC_ERR=0, the held address=0, init_cnt=0, and INIT_DONE=0 (INIT_DONE=1 if INIT_EN=0).
REQ-028 Reset asserted during INIT SHALL restart the fill at entry 0.
REQ-029 Reset in READY with INIT_EN=0 SHALL leave array contents unchanged.
REQ-030 While in INIT, Q SHALL remain 0.

Verification
REQ-031 Scenario: default parameters, release reset, hold CEN=1 -> INIT_DONE=0 for 2048 cycles, rises at cycle 2048; reading every address returns 0.
REQ-032 Scenario: after init, write A=5, D=all-ones, GWEN=0, WEN=0; then read A=5 -> Q=all-ones 1 cycle later (2 cycles with OUT_REG=1).
REQ-033 Scenario: A=5 holds all-ones; write D=0 with WEN[28]=0 and WEN[57]=1, WEN[58]=1 -> Q the next cycle has bits 28:0 = 0 and bits 58:29 = 1.
REQ-034 Scenario: read A=7 holding 0x1, then CEN=1 while A toggles randomly -> Q stays 0x1.
REQ-035 Scenario: CEN=0, GWEN=0 at cycle 100 of init -> no write occurs, ACC_ERR=1 and stays 1 after INIT_DONE; reset clears it.
REQ-036 Scenario: reset pulse at init cycle 1000 -> init_cnt restarts at 0 and INIT_DONE rises 2048 cycles after the release.
